// File: rtl/fu_wb_arbiter_if.sv
// Writeback bus between the functional units and the CDB arbiter.
// The master side drives FU completions; the slave side is the arbiter.
interface fu_wb_arbiter_if #(
   parameter int DW = 32,
   parameter int TW = 5
);
   logic [3:0]      finish_i;
   logic [4*DW-1:0] res_i;
   logic [4*TW-1:0] tag_i;
   logic [3:0]      full_o;
   logic            cdb_valid_o;
   logic [TW-1:0]   cdb_tag_o;
   logic [DW-1:0]   cdb_data_o;
   logic [1:0]      cdb_src_o;
   logic [3:0]      ovf_o;

   modport master (
      output finish_i, res_i, tag_i,
      input  full_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o, ovf_o
   );

   modport slave (
      input  finish_i, res_i, tag_i,
      output full_o, cdb_valid_o, cdb_tag_o, cdb_data_o, cdb_src_o, ovf_o
   );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Four 2-entry result FIFOs (ALU, MEM, MUL, DIV) feeding a round-robin
// arbiter that broadcasts one {tag, data} per cycle on the registered CDB.
module fu_wb_arbiter #(
   parameter int DW = 32,
   parameter int TW = 5
) (
   input logic             clk,
   input logic             rst,
   fu_wb_arbiter_if.slave  bus
);
   localparam int EW = TW + DW;

   logic [3:0][EW-1:0] head;
   logic [3:0]         nonempty;
   logic [3:0]         pop;
   logic [1:0]         rr_ptr_reg;
   logic               grant_valid;
   logic [1:0]         grant_idx;
   logic [1:0]         probe_idx;

   // Walk the offsets downward so the lowest offset from rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = rr_ptr_reg;
      probe_idx   = rr_ptr_reg;
      for (int k = 3; k >= 0; k--) begin
         probe_idx = rr_ptr_reg + 2'(k);
         if (nonempty[probe_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = probe_idx;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_port
         logic [EW-1:0] mem_reg [2];
         logic          rd_ptr_reg;
         logic          wr_ptr_reg;
         logic [1:0]    count_reg;
         logic          ovf_reg;
         logic          push;

         // A full FIFO still accepts when its head leaves at the same edge;
         // the new entry lands in the slot being vacated.
         assign pop[gi]        = grant_valid && (grant_idx == 2'(gi));
         assign push           = bus.finish_i[gi] && ((count_reg != 2'd2) || pop[gi]);
         assign nonempty[gi]   = (count_reg != 2'd0);
         assign head[gi]       = mem_reg[rd_ptr_reg];
         assign bus.full_o[gi] = (count_reg == 2'd2);
         assign bus.ovf_o[gi]  = ovf_reg;

         always_ff @(posedge clk) begin
            if (push && !rst) begin
               mem_reg[wr_ptr_reg] <= {bus.tag_i[gi*TW +: TW], bus.res_i[gi*DW +: DW]};
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_ptr_reg <= 1'b0;
               wr_ptr_reg <= 1'b0;
               count_reg  <= 2'd0;
               ovf_reg    <= 1'b0;
            end else begin
               if (push) begin
                  wr_ptr_reg <= ~wr_ptr_reg;
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= ~rd_ptr_reg;
               end
               count_reg <= count_reg + 2'(push) - 2'(pop[gi]);
               if (bus.finish_i[gi] && !push) begin
                  ovf_reg <= 1'b1;
               end
            end
         end
      end
   endgenerate

   // Idle cycles drop valid but keep the last broadcast on the bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg      <= 2'd0;
         bus.cdb_valid_o <= 1'b0;
         bus.cdb_tag_o   <= '0;
         bus.cdb_data_o  <= '0;
         bus.cdb_src_o   <= 2'd0;
      end else if (grant_valid) begin
         rr_ptr_reg      <= grant_idx + 2'd1;
         bus.cdb_valid_o <= 1'b1;
         bus.cdb_tag_o   <= head[grant_idx][EW-1:DW];
         bus.cdb_data_o  <= head[grant_idx][DW-1:0];
         bus.cdb_src_o   <= grant_idx;
      end else begin
         bus.cdb_valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the writeback rules.
module tb_fu_wb_arbiter;
   localparam int DW = 32;
   localparam int TW = 5;
   localparam int EW = TW + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   fu_wb_arbiter_if #(.DW(DW), .TW(TW)) bus ();

   fu_wb_arbiter #(.DW(DW), .TW(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [EW-1:0] mq [4][$];
   int            m_rr;
   logic          m_valid;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_data;
   logic [1:0]    m_src;
   logic [3:0]    m_ovf;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic void model_edge(input logic r, input logic [3:0] f,
                                      input logic [4*TW-1:0] t, input logic [4*DW-1:0] d);
      int g;
      logic [EW-1:0] e;
      if (r) begin
         for (int p = 0; p < 4; p++) mq[p].delete();
         m_rr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 2'd0; m_ovf = 4'd0;
         return;
      end
      g = -1;
      for (int k = 0; k < 4; k++) begin
         if (g < 0 && mq[(m_rr + k) % 4].size() > 0) g = (m_rr + k) % 4;
      end
      if (g >= 0) begin
         e = mq[g].pop_front();
         m_valid = 1'b1;
         m_tag   = e[EW-1:DW];
         m_data  = e[DW-1:0];
         m_src   = 2'(g);
         m_rr    = (g + 1) % 4;
      end else begin
         m_valid = 1'b0;
      end
      for (int p = 0; p < 4; p++) begin
         if (f[p]) begin
            if (mq[p].size() < 2) mq[p].push_back({t[p*TW +: TW], d[p*DW +: DW]});
            else m_ovf[p] = 1'b1;
         end
      end
   endfunction

   task automatic compare_all();
      logic [3:0] exp_full;
      for (int p = 0; p < 4; p++) exp_full[p] = (mq[p].size() == 2);
      check("cdb_valid", 64'(bus.cdb_valid_o), 64'(m_valid));
      check("cdb_tag",   64'(bus.cdb_tag_o),   64'(m_tag));
      check("cdb_data",  64'(bus.cdb_data_o),  64'(m_data));
      check("cdb_src",   64'(bus.cdb_src_o),   64'(m_src));
      check("full",      64'(bus.full_o),      64'(exp_full));
      check("ovf",       64'(bus.ovf_o),       64'(m_ovf));
      if (bus.cdb_valid_o)
         $display("cyc %0d: bcast src %0d tag %0d data %08h", cyc, bus.cdb_src_o, bus.cdb_tag_o, bus.cdb_data_o);
   endtask

   task automatic step(input logic r, input logic [3:0] f,
                       input logic [4*TW-1:0] t, input logic [4*DW-1:0] d);
      rst = r;
      bus.finish_i = f;
      bus.tag_i    = t;
      bus.res_i    = d;
      @(posedge clk);
      model_edge(r, f, t, d);
      cyc++;
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, '0);
   endtask

   function automatic logic [4*TW-1:0] tags_of(input int base);
      logic [4*TW-1:0] t;
      for (int p = 0; p < 4; p++) t[p*TW +: TW] = TW'(base + p);
      return t;
   endfunction

   function automatic logic [4*DW-1:0] data_of(input int base);
      logic [4*DW-1:0] d;
      for (int p = 0; p < 4; p++) d[p*DW +: DW] = DW'(32'h100 * (base + p) + 32'h5a);
      return d;
   endfunction

   initial begin
      logic [4*TW-1:0] t;
      logic [4*DW-1:0] d;
      logic [3:0]      f;
      int              density;

      bus.finish_i = '0;
      bus.tag_i    = '0;
      bus.res_i    = '0;

      step(1'b1, 4'hf, tags_of(1), data_of(1));
      step(1'b1, 4'd0, '0, '0);
      check("reset_valid", 64'(bus.cdb_valid_o), 64'd0);
      check("reset_full",  64'(bus.full_o), 64'd0);

      // Single completion on MUL: visible on the CDB exactly two edges later.
      t = '0; d = '0;
      t[2*TW +: TW] = TW'(7);
      d[2*DW +: DW] = 32'h0000_0030;
      step(1'b0, 4'b0100, t, d);
      check("single_early", 64'(bus.cdb_valid_o), 64'd0);
      idle(1);
      check("single_valid", 64'(bus.cdb_valid_o), 64'd1);
      check("single_tag",   64'(bus.cdb_tag_o), 64'd7);
      check("single_data",  64'(bus.cdb_data_o), 64'h30);
      check("single_src",   64'(bus.cdb_src_o), 64'd2);
      idle(1);
      check("single_late",  64'(bus.cdb_valid_o), 64'd0);

      // Contention from reset state: all four ports at one edge.
      step(1'b1, 4'd0, '0, '0);
      step(1'b0, 4'hf, tags_of(10), data_of(10));
      for (int i = 0; i < 4; i++) begin
         idle(1);
         check("contend_src", 64'(bus.cdb_src_o), 64'(i));
      end
      idle(2);

      // Round-robin: port 2 granted, then ports 3 and 0 pending.
      step(1'b0, 4'b0100, tags_of(20), data_of(20));
      step(1'b0, 4'b1001, tags_of(24), data_of(24));
      idle(1);
      check("rr_first", 64'(bus.cdb_src_o), 64'd3);
      idle(1);
      check("rr_second", 64'(bus.cdb_src_o), 64'd0);
      idle(2);

      // Overflow on port 3 while ports 0-2 keep the bus saturated.
      for (int i = 0; i < 4; i++) step(1'b0, 4'hf, tags_of(4 * i), data_of(4 * i));
      check("ovf_full3", 64'(bus.full_o[3]), 64'd1);
      check("ovf_flag3", 64'(bus.ovf_o[3]), 64'd1);
      idle(14);

      // Full FIFO 1 popped and pushed at the same edge.
      step(1'b1, 4'd0, '0, '0);
      step(1'b0, 4'b0011, tags_of(1), data_of(1));
      step(1'b0, 4'b0011, tags_of(5), data_of(5));
      check("fp_full1", 64'(bus.full_o[1]), 64'd1);
      step(1'b0, 4'b0010, tags_of(9), data_of(9));
      check("fp_full1_kept", 64'(bus.full_o[1]), 64'd1);
      check("fp_no_ovf", 64'(bus.ovf_o), 64'd0);
      idle(6);

      // Reset mid-burst drops everything buffered.
      step(1'b0, 4'b0111, tags_of(3), data_of(3));
      step(1'b0, 4'b0111, tags_of(7), data_of(7));
      step(1'b1, 4'hf, tags_of(11), data_of(11));
      check("rstmid_valid", 64'(bus.cdb_valid_o), 64'd0);
      check("rstmid_data",  64'(bus.cdb_data_o), 64'd0);
      idle(3);

      // Random traffic with varying load and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         density = (i / 500) % 3;
         for (int p = 0; p < 4; p++) begin
            f[p] = ($urandom_range(0, 7) < 2 * density + 1);
            t[p*TW +: TW] = TW'($urandom);
            d[p*DW +: DW] = DW'($urandom);
         end
         step(($urandom_range(0, 299) == 0), f, t, d);
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fu_wb_arbiter.md
FU_WB_ARBITER -- requirements
Module: fu_wb_arbiter

Interface
REQ-001 Parameter: DW, default 32, result data width.
REQ-002 Parameter: TW, default 5, reservation-station tag width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: finish_i  input  4  per-FU completion pulse (bit0 ALU, bit1 MEM, bit2 MUL, bit3 DIV), one cycle wide, sampled at rising edge.
REQ-006 Port: res_i  input  4*DW  per-FU result, port p at bits [p*DW +: DW], valid only with finish_i[p].
REQ-007 Port: tag_i  input  4*TW  per-FU destination tag, port p at bits [p*TW +: TW], valid only with finish_i[p].
REQ-008 Port: full_o  output  4  per-port buffer full; issue logic withholds FU EN while set.
REQ-009 Port: cdb_valid_o  output  1  common data bus broadcast valid, registered.
REQ-010 Port: cdb_tag_o  output  TW  broadcast tag, registered.
REQ-011 Port: cdb_data_o  output  DW  broadcast result, registered.
REQ-012 Port: cdb_src_o  output  2  index of FU that produced the broadcast, registered.
REQ-013 Port: ovf_o  output  4  sticky per-port overflow flag.

Function
REQ-014 Each port SHALL own a 2-entry FIFO of {tag, data}; FUs cannot stall, so finish_i is never back-pressured.
REQ-015 finish_i[p] high at edge SHALL push {tag_i[p], res_i[p]} into FIFO p if FIFO p is not full or is popped at the same edge.
REQ-016 Push to a full FIFO not popped at that edge SHALL drop the entry, leave FIFO contents unchanged, and set ovf_o[p]; ovf_o[p] clears only on rst.
REQ-017 full_o[p] SHALL be high exactly when FIFO p holds 2 entries (combinational from occupancy count).
REQ-018 Arbitration SHALL be combinational over FIFO heads: round-robin, search order starting at rr_ptr, rr_ptr+1, ... modulo 4.
REQ-019 At each edge with at least one non-empty FIFO, the granted FIFO SHALL pop exactly one entry and cdb_*_o SHALL load its tag, data, and port index, with cdb_valid_o=1.
REQ-020 At each edge with all FIFOs empty, cdb_valid_o SHALL go 0; cdb_tag_o, cdb_data_o, cdb_src_o SHALL hold their previous values.
REQ-021 After a grant to port g, rr_ptr SHALL become (g+1) mod 4; with no grant rr_ptr SHALL hold.
REQ-022 Uncontended latency: finish_i sampled at edge k -> entry in FIFO during cycle k+1 -> cdb_valid_o high during cycle k+2 (exactly one cycle per entry).
REQ-023 Entries from one port SHALL broadcast in arrival order; at most one broadcast per cycle.
REQ-024 A push and pop on the same FIFO at the same edge SHALL leave occupancy unchanged; newly pushed entry is never granted in its push cycle.
REQ-025 Sustained throughput: one broadcast per cycle while any FIFO is non-empty; no idle cycles between grants.

Reset
REQ-026 rst high at edge SHALL empty all FIFOs, set rr_ptr=0, cdb_valid_o=0, cdb_tag_o=0, cdb_data_o=0, cdb_src_o=0, ovf_o=0; full_o=0 follows.
REQ-027 rst SHALL dominate: finish_i sampled at the same edge as rst is discarded; rst mid-burst discards all buffered entries.
REQ-028 First cycle after rst low SHALL accept finish_i normally.

Verification
REQ-029 Single: finish_i=0100, tag_i[2]=5'd7, res_i[2]=32'h0000_0030 at edge k -> cdb_valid_o=1, tag 7, data 30h, src 2 during cycle k+2 only.
REQ-030 Contention: all four finish_i at same edge after reset -> broadcasts in cycles k+2..k+5 with src 0,1,2,3, no gaps, full_o stays 0.
REQ-031 Round-robin: after grant to port 2, ports 0 and 3 both pending -> port 3 granted first, then port 0.
REQ-032 Overflow: hold finish_i[3]=1 for 4 consecutive edges while ports 0-2 saturate the bus -> full_o[3]=1, ovf_o[3]=1, exactly 2 port-3 entries later broadcast, first two tags in order.
REQ-033 Full with pop: FIFO 1 full, grant to port 1 and finish_i[1] at same edge -> no overflow, occupancy stays 2, order preserved.
REQ-034 Reset mid-burst: rst with 3 FIFOs occupied and cdb_valid_o=1 -> next cycle all outputs 0, no stale entry ever broadcast.
